// File: rtl/alu_op_controller_pkg.sv
// Shared definitions for the ALU operation controller.
//   - 2-bit opcodes, which double as the select code of the result mux bank
//   - FSM state encodings used by the controller and exposed on its debug port
package alu_op_controller_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generator for the ALU result.
// Ports:
//   op       in  2      operation in flight (mux select)
//   a, b     in  WIDTH  operands driven to the datapath
//   result   in  WIDTH  mux-bank output
//   cout     in  1      adder/subtractor carry-out
//   zero     out 1      result is all zeros (every op)
//   carry    out 1      cout for ADD/SUB, 0 for logic ops
//   overflow out 1      signed overflow for ADD/SUB, 0 for logic ops
module alu_flag_gen
  import alu_op_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic             cout,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  logic a_msb, b_msb, r_msb;

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign r_msb = result[WIDTH-1];

  always_comb begin
    zero     = ~|result;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        carry    = cout;
        overflow = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        carry    = cout;
        overflow = (a_msb != b_msb) && (r_msb != a_msb);
      end
      default: begin
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_controller.sv
// Sequencer in front of the ALU's per-bit 4:1 result mux bank.
// Accepts one op per input handshake, drives registered select/operands,
// waits SETTLE_CYCLES edges, captures result + flags, and holds them on the
// output handshake until consumed.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised by the producer, and the payload stay stable
// until that edge; ready may be raised or dropped freely.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake; in_op/in_a/in_b payload
//   sel, alu_a, alu_b        registered drive to the mux bank / datapath
//   alu_result, alu_cout     datapath response
//   out_valid/out_ready      result handshake; out_result + flags payload
//   op_count                 completed output handshakes (wraps)
//   state_dbg                current FSM state (debug)
module alu_op_controller
  import alu_op_controller_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_overflow,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_zero_q, out_zero_d;
  logic             out_carry_q, out_carry_d;
  logic             out_overflow_q, out_overflow_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic flag_zero, flag_carry, flag_overflow;

  // Flags are derived from the registered select/operands, i.e. the op
  // currently on the datapath, not from the incoming request.
  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op       (sel_q),
    .a        (alu_a_q),
    .b        (alu_b_q),
    .result   (alu_result),
    .cout     (alu_cout),
    .zero     (flag_zero),
    .carry    (flag_carry),
    .overflow (flag_overflow)
  );

  assign in_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_zero_d     = out_zero_q;
    out_carry_d    = out_carry_q;
    out_overflow_d = out_overflow_q;
    op_count_d     = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sel_d   = in_op;
          alu_a_d = in_a;
          alu_b_d = in_b;
          // Counting down from SETTLE_CYCLES-1 puts the capture on the
          // SETTLE_CYCLES-th edge after the accept.
          cnt_d   = CW'(SETTLE_CYCLES - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          out_result_d   = alu_result;
          out_zero_d     = flag_zero;
          out_carry_d    = flag_carry;
          out_overflow_d = flag_overflow;
          out_valid_d    = 1'b1;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sel_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_zero_q     <= out_zero_d;
      out_carry_q    <= out_carry_d;
      out_overflow_q <= out_overflow_d;
      op_count_q     <= op_count_d;
    end
  end

  assign sel          = sel_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_zero     = out_zero_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign op_count     = op_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_alu_op_controller.sv
module tb_alu_op_controller;

  localparam int W = 8;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (SETTLE_CYCLES=1) ----------------
  logic             in_valid = 1'b0, in_ready;
  logic [1:0]       in_op = '0;
  logic [W-1:0]     in_a = '0, in_b = '0;
  logic [1:0]       sel;
  logic [W-1:0]     alu_a, alu_b, alu_result;
  logic             alu_cout;
  logic             out_valid, out_ready = 1'b0;
  logic [W-1:0]     out_result;
  logic             out_zero, out_carry, out_overflow;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       state_dbg;
  logic             force_cout = 1'b0;

  alu_op_controller #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .sel(sel), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_overflow(out_overflow),
    .op_count(op_count), .state_dbg(state_dbg)
  );

  // Behavioural mux bank: i1=AND, i2=OR, i3=ADD, i4=SUB (a + ~b + 1).
  always_comb begin
    logic [W:0] sum;
    sum = '0;
    case (sel)
      2'b00: sum = {1'b0, alu_a & alu_b};
      2'b01: sum = {1'b0, alu_a | alu_b};
      2'b10: sum = {1'b0, alu_a} + {1'b0, alu_b};
      default: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + (W+1)'(1);
    endcase
    alu_result = sum[W-1:0];
    alu_cout   = force_cout ? 1'b1 : sum[W];
  end

  // ---------------- DUT 3 (SETTLE_CYCLES=3) ----------------
  logic             in_valid3 = 1'b0, in_ready3;
  logic [1:0]       sel3;
  logic [W-1:0]     alu_a3, alu_b3;
  logic             out_valid3;
  logic [W-1:0]     out_result3;
  logic             out_zero3, out_carry3, out_overflow3;
  logic [CNT_W-1:0] op_count3;
  logic [1:0]       state_dbg3;
  logic [W-1:0]     cyc3 = '0;

  // Result that changes every cycle, to pin down the capture edge.
  always @(posedge clk) cyc3 <= cyc3 + 8'd1;

  alu_op_controller #(.WIDTH(W), .SETTLE_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_op(2'b00), .in_a(8'h00), .in_b(8'h00), .sel(sel3), .alu_a(alu_a3),
    .alu_b(alu_b3), .alu_result(cyc3), .alu_cout(1'b0),
    .out_valid(out_valid3), .out_ready(1'b0), .out_result(out_result3),
    .out_zero(out_zero3), .out_carry(out_carry3), .out_overflow(out_overflow3),
    .op_count(op_count3), .state_dbg(state_dbg3)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (drive and sample on negedge) ----------------
  // Presents a request, lets it be accepted, and leaves the DUT in EXEC.
  task automatic accept(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("exec_state", {30'b0, state_dbg}, 32'd1);
    chk("exec_sel", {30'b0, sel}, {30'b0, op});
    chk("exec_no_valid", {31'b0, out_valid}, 32'd0);
  endtask

  // One edge after accept the result must be valid with the given payload.
  task automatic expect_done(input string tag, input logic [W-1:0] r,
                             input logic z, input logic c, input logic v);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_result"}, {24'b0, out_result}, {24'b0, r});
    chk({tag, "_zero"}, {31'b0, out_zero}, {31'b0, z});
    chk({tag, "_carry"}, {31'b0, out_carry}, {31'b0, c});
    chk({tag, "_ovf"}, {31'b0, out_overflow}, {31'b0, v});
  endtask

  task automatic release_out(input logic [CNT_W-1:0] exp_cnt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("rel_valid", {31'b0, out_valid}, 32'd0);
    chk("rel_count", {16'b0, op_count}, {16'b0, exp_cnt});
    chk("rel_idle", {30'b0, state_dbg}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] c0, exp3;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sel", {30'b0, sel}, 32'd0);
    chk("rst_alu_a", {24'b0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'b0, alu_b}, 32'd0);
    chk("rst_result", {24'b0, out_result}, 32'd0);
    chk("rst_flags", {29'b0, out_zero, out_carry, out_overflow}, 32'd0);
    chk("rst_count", {16'b0, op_count}, 32'd0);
    rst = 1'b0;

    // 1. ADD 7F+01 -> 80, signed overflow, no carry
    accept(2'b10, 8'h7F, 8'h01);
    expect_done("add", 8'h80, 1'b0, 1'b0, 1'b1);
    release_out(16'd1);

    // 2. SUB 05-05 -> 00, zero, no-borrow carry 1
    accept(2'b11, 8'h05, 8'h05);
    expect_done("sub", 8'h00, 1'b1, 1'b1, 1'b0);
    release_out(16'd2);

    // 3. Logic ops ignore carry-out; OR of zeros sets zero
    force_cout = 1'b1;
    accept(2'b00, 8'hF0, 8'h3C);
    expect_done("and", 8'h30, 1'b0, 1'b0, 1'b0);
    release_out(16'd3);
    accept(2'b01, 8'h00, 8'h00);
    expect_done("or", 8'h00, 1'b1, 1'b0, 1'b0);
    release_out(16'd4);
    force_cout = 1'b0;

    // Signed SUB overflow: 80-01 -> 7F
    accept(2'b11, 8'h80, 8'h01);
    expect_done("subovf", 8'h7F, 1'b0, 1'b1, 1'b1);
    release_out(16'd5);

    // 4. Back-pressure in DONE; a request arriving there is dropped
    accept(2'b10, 8'h12, 8'h34);
    expect_done("bp", 8'h46, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1) || (i == 2);
      in_op = 2'b01; in_a = 8'hAA; in_b = 8'h55;
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", {24'b0, out_result}, 32'h46);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_count", {16'b0, op_count}, 32'd5);
    end
    in_valid = 1'b0;
    release_out(16'd6);
    @(negedge clk);
    chk("drop_idle", {30'b0, state_dbg}, 32'd0);
    chk("drop_sel", {30'b0, sel}, 32'd2);
    chk("drop_alu_a", {24'b0, alu_a}, 32'h12);
    chk("drop_alu_b", {24'b0, alu_b}, 32'h34);

    // 5. SETTLE=3: capture happens on the 3rd edge after accept
    @(negedge clk);
    in_valid3 = 1'b1;
    chk("s3_in_ready", {31'b0, in_ready3}, 32'd1);
    @(negedge clk);
    in_valid3 = 1'b0;
    c0 = cyc3;              // value in front of edge 1 after accept
    exp3 = c0 + 8'd2;       // value in front of edge 3
    chk("s3_e0", {31'b0, out_valid3}, 32'd0);
    @(negedge clk);
    chk("s3_e1", {31'b0, out_valid3}, 32'd0);
    @(negedge clk);
    chk("s3_e2", {31'b0, out_valid3}, 32'd0);
    @(negedge clk);
    chk("s3_e3", {31'b0, out_valid3}, 32'd1);
    chk("s3_result", {24'b0, out_result3}, {24'b0, exp3});
    chk("s3_zero", {31'b0, out_zero3}, {31'b0, (exp3 == 8'h00)});
    chk("s3_state", {30'b0, state_dbg3}, 32'd2);

    // 6. Reset during EXEC aborts the op
    accept(2'b10, 8'h10, 8'h20);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_count", {16'b0, op_count}, 32'd0);
    chk("abort_sel", {30'b0, sel}, 32'd0);
    chk("abort_state", {30'b0, state_dbg}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_abort_valid", {31'b0, out_valid}, 32'd0);
    accept(2'b10, 8'h01, 8'h01);
    expect_done("post", 8'h02, 1'b0, 1'b0, 1'b0);
    release_out(16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
